des_key_schedule_pipelined: RTL and testbench
=============================================

# des_key_schedule_pipelined

Pipelined DES key schedule that feeds the per-round subkeys `Kn` to the 16-stage round-function pipeline. One 64-bit key is accepted per cycle. Each round's 48-bit subkey is presented on a dedicated output, skewed in time so that round stage n sees the key belonging to the data word currently in that stage. Supports encryption (K1..K16) and decryption (K16..K1) order, carried per key through the pipeline.

## Interface
Parameters:
- `NUM_ROUNDS`, 16: number of subkey stages; only 16 is supported.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: `key_in`/`decrypt` valid this cycle.
- `enable` in 1: advance the pipeline; when low, every register holds.
- `restart_block` in 1: clear all valid bits, keeping data.
- `key_in` in [1:64]: DES key, parity bits 8,16,…,64 ignored.
- `decrypt` in 1: 1 means subkeys are produced in reverse order.
- `k_out` out [1:768]: subkey for stage n at bits [48(n-1)+1 : 48n].
- `k_valid` out [1:16]: bit n means stage n subkey is valid.
- `o_decrypt` out [1:16]: mode bit held in stage n.

## Operation
- Stage register n (n = 1..16) holds C_n (28 bits), D_n (28 bits), mode bit, and valid bit. Subkey n = PC2(C_n‖D_n), combinational from stage n.
- Stage 1 loads from input. Encrypt: C_1/D_1 = rotl(PC1(key_in) halves, 1). Decrypt: C_1/D_1 = PC1 halves unrotated.
- Stage n loads from stage n-1:
  - Encrypt: rotate left by SHIFT[n] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: rotate right by RSHIFT[n] = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - The result is that stage n delivers K_n in encrypt mode and K_{17-n} in decrypt mode.
- Rotation is per 28-bit half, modulo 28. C and D never mix.
- Valid bit: stage 1 valid ← `i_valid`; stage n valid ← stage n-1 valid.
- Data registers load unconditionally whenever `enable`=1. Their contents are don't-care while valid is 0.
- Priority, highest first:
  1. `rst`: all valid bits, mode bits, and C/D registers cleared to 0.
  2. `restart_block`: all valid bits cleared, C/D and mode hold.
  3. `enable`=0: everything holds, including valid bits.
  4. Normal shift.
- `restart_block` together with `enable`=1: valids clear and data still shifts. No key accepted that cycle becomes valid.
- No backpressure or ready signal exists. The upstream side must not present `i_valid` while `enable`=0; such keys are dropped.

## Timing
- Reset values: `k_valid` = 0, `o_decrypt` = 0, `k_out` = PC2(0) = 0.
- A key accepted at edge E (with `i_valid`=1 and `enable`=1) appears in stage n after edge E+n-1 if every intervening edge has `enable`=1. Latency to stage 1 is 1 cycle; to stage 16 it is 16 cycles.
- Throughput is one key per enabled cycle. Back-to-back keys with different `decrypt` values do not interfere.
- Alignment rule: the round-function stage n samples `k_out` stage n in the same cycle it samples its L/R input. The top level feeds round n from key stage n.
- `rst` or `restart_block` mid-stream: every in-flight key is lost, and `k_valid` reads 0 on the next cycle.
- An `enable` low for any number of cycles adds exactly that many cycles of latency. No bubble is inserted or removed.

## Structure
- Package `des_pkg` holds:
  - PC1 table (56 entries) and PC2 table (48 entries).
  - SHIFT and RSHIFT arrays (16 entries each).
  - Constants: subkey width 48, half width 28.
- Sub-module `des_key_stage`, parameter `ROUND`:
  - Contents: one C/D/mode/valid register set, the left/right rotation mux, and the PC2 output.
  - Instantiated 16 times by a generate loop.
  - Stage 1 is preceded by a combinational PC1 block in the top module.

## Test plan
- Encrypt, key 133457799BBCDFF1: stage 1 gives 1B02EFFC7072 one cycle after acceptance; stage 16 gives CB3D8B0E17F5 sixteen cycles after acceptance. Stage 1 C/D = E19955F / AAACCF1.
- Decrypt, same key: stage 1 gives CB3D8B0E17F5 and stage 16 gives 1B02EFFC7072. `o_decrypt` is 1 in each stage while that key passes through it.
- Back-to-back stream of 20 keys with `decrypt` alternating 0/1: every stage-n output matches a software model. `k_valid` stays all-ones once filled.
- `enable` low for 5 cycles with keys in stages 3–7: outputs, valids, and mode bits frozen throughout. Stage 16 arrival is delayed by exactly 5 cycles.
- `restart_block` pulse with the pipeline full: next cycle `k_valid` = 0. A key presented in the restart cycle never becomes valid; a key presented the following cycle appears normally.
- `rst` pulse mid-stream: next cycle `k_valid` = 0, `o_decrypt` = 0, and every subkey = 0. After `rst` deasserts, the first accepted key reaches stage 16 after 16 cycles.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: DES key schedule tables, widths and bit-permutation/rotation helpers.
package des_pkg;
  localparam int KEY_W = 48;
  localparam int HALF_W = 28;
  localparam int PC1 [1:56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [1:48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RSHIFT [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  function automatic logic [1:2*HALF_W] pc1(input logic [1:64] k);
    logic [1:2*HALF_W] r;
    for (int i = 1; i <= 2 * HALF_W; i++) r[i] = k[PC1[i]];
    return r;
  endfunction
  function automatic logic [1:KEY_W] pc2(input logic [1:2*HALF_W] cd);
    logic [1:KEY_W] r;
    for (int i = 1; i <= KEY_W; i++) r[i] = cd[PC2[i]];
    return r;
  endfunction
  // bit 1 is the MSB, so a left shift moves bits toward index 1
  function automatic logic [1:HALF_W] rotl(input logic [1:HALF_W] x, input int s);
    return (x << s) | (x >> (HALF_W - s));
  endfunction
  function automatic logic [1:HALF_W] rotr(input logic [1:HALF_W] x, input int s);
    return (x >> s) | (x << (HALF_W - s));
  endfunction
endpackage

// File: rtl/des_key_stage.sv
// des_key_stage: one key-schedule stage holding C/D/mode/valid and emitting its PC2 subkey.
module des_key_stage
  import des_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart_block,
  input  logic              enable,
  input  logic              valid_i,
  input  logic              dec_i,
  input  logic [1:HALF_W]   c_i,
  input  logic [1:HALF_W]   d_i,
  output logic              valid_o,
  output logic              dec_o,
  output logic [1:HALF_W]   c_o,
  output logic [1:HALF_W]   d_o,
  output logic [1:KEY_W]    k_o
);
  logic [1:HALF_W] c_q, d_q, c_d, d_d;
  logic dec_q, valid_q;
  always_comb begin
    c_d = dec_i ? rotr(c_i, RSHIFT[ROUND]) : rotl(c_i, SHIFT[ROUND]);
    d_d = dec_i ? rotr(d_i, RSHIFT[ROUND]) : rotl(d_i, SHIFT[ROUND]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
      dec_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (enable) begin
        c_q <= c_d;
        d_q <= d_d;
        dec_q <= dec_i;
      end
      valid_q <= restart_block ? 1'b0 : enable ? valid_i : valid_q;
    end
  end
  assign c_o = c_q;
  assign d_o = d_q;
  assign dec_o = dec_q;
  assign valid_o = valid_q;
  assign k_o = pc2({c_q, d_q});
endmodule

// File: rtl/des_key_schedule_pipelined.sv
// des_key_schedule_pipelined: 16-stage DES subkey pipeline, stage n presents K_n (encrypt) or K_17-n (decrypt).
module des_key_schedule_pipelined
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic                        enable,
  input  logic                        restart_block,
  input  logic [1:64]                 key_in,
  input  logic                        decrypt,
  output logic [1:KEY_W*NUM_ROUNDS]   k_out,
  output logic [1:NUM_ROUNDS]         k_valid,
  output logic [1:NUM_ROUNDS]         o_decrypt
);
  logic [1:HALF_W] c_s [NUM_ROUNDS+1];
  logic [1:HALF_W] d_s [NUM_ROUNDS+1];
  logic [NUM_ROUNDS:0] v_s, m_s;
  // index 0 of each chain is the PC1 view of the incoming key
  assign {c_s[0], d_s[0]} = pc1(key_in);
  assign v_s[0] = i_valid;
  assign m_s[0] = decrypt;
  for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_stage
    des_key_stage #(.ROUND(i + 1)) u_stage (
      .clk(clk),
      .rst(rst),
      .restart_block(restart_block),
      .enable(enable),
      .valid_i(v_s[i]),
      .dec_i(m_s[i]),
      .c_i(c_s[i]),
      .d_i(d_s[i]),
      .valid_o(v_s[i+1]),
      .dec_o(m_s[i+1]),
      .c_o(c_s[i+1]),
      .d_o(d_s[i+1]),
      .k_o(k_out[KEY_W*i+1 +: KEY_W])
    );
    assign k_valid[i+1] = v_s[i+1];
    assign o_decrypt[i+1] = m_s[i+1];
  end
endmodule

// File: tb/tb_des_key_schedule_pipelined.sv
// tb_des_key_schedule_pipelined: directed checks against known DES subkeys and a behavioural pipeline model.
module tb_des_key_schedule_pipelined;
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] K2 = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic enable = 1'b1;
  logic restart_block = 1'b0;
  logic decrypt = 1'b0;
  logic [63:0] key_in = '0;
  logic [767:0] k_out;
  logic [15:0] k_valid, o_decrypt;
  logic [63:0] mk [1:16];
  logic mm [1:16];
  logic mv [1:16];
  logic mz [1:16];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  des_key_schedule_pipelined dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .enable(enable),
    .restart_block(restart_block),
    .key_in(key_in),
    .decrypt(decrypt),
    .k_out(k_out),
    .k_valid(k_valid),
    .o_decrypt(o_decrypt)
  );
  function automatic logic [47:0] ks(input logic [63:0] key, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    int sh = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < r; i++) sh += SH[i];
    for (int i = 0; i < sh; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_T[i]];
    return k;
  endfunction
  function automatic logic [47:0] sk(input int n);
    return k_out[767-48*(n-1) -: 48];
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [15:0] ev, em;
    @(posedge clk);
    if (rst) begin
      for (int n = 1; n <= 16; n++) begin
        mv[n] = 1'b0;
        mm[n] = 1'b0;
        mz[n] = 1'b1;
      end
    end else begin
      if (enable) begin
        for (int n = 16; n > 1; n--) begin
          mk[n] = mk[n-1];
          mm[n] = mm[n-1];
          mz[n] = mz[n-1];
        end
        mk[1] = key_in;
        mm[1] = decrypt;
        mz[1] = 1'b0;
      end
      if (restart_block) begin
        for (int n = 1; n <= 16; n++) mv[n] = 1'b0;
      end else if (enable) begin
        for (int n = 16; n > 1; n--) mv[n] = mv[n-1];
        mv[1] = i_valid;
      end
    end
    @(negedge clk);
    for (int n = 1; n <= 16; n++) begin
      ev[16-n] = mv[n];
      em[16-n] = mm[n];
    end
    chk("k_valid", 64'(k_valid), 64'(ev));
    chk("o_decrypt", 64'(o_decrypt), 64'(em));
    for (int n = 1; n <= 16; n++) begin
      if (mz[n]) chk($sformatf("k_zero%0d", n), 64'(sk(n)), 64'd0);
      else if (mv[n]) chk($sformatf("k_stage%0d", n), 64'(sk(n)), 64'(ks(mk[n], mm[n] ? 17 - n : n)));
    end
  endtask
  initial begin
    int t;
    tick();
    tick();
    chk("rst_valid", 64'(k_valid), 64'd0);
    chk("rst_mode", 64'(o_decrypt), 64'd0);
    chk("rst_kout", 64'(k_out == '0), 64'd1);
    rst = 1'b0;
    key_in = KEY;
    i_valid = 1'b1;
    tick();
    chk("enc_k1", 64'(sk(1)), 64'(K1));
    i_valid = 1'b0;
    tick();
    chk("enc_k2", 64'(sk(2)), 64'(K2));
    repeat (14) tick();
    chk("enc_k16", 64'(sk(16)), 64'(K16));
    chk("enc_v16", 64'(k_valid), 64'h0001);
    decrypt = 1'b1;
    i_valid = 1'b1;
    tick();
    chk("dec_k1", 64'(sk(1)), 64'(K16));
    chk("dec_mode1", 64'(o_decrypt[15]), 64'd1);
    i_valid = 1'b0;
    decrypt = 1'b0;
    repeat (15) tick();
    chk("dec_k16", 64'(sk(16)), 64'(K1));
    chk("dec_mode16", 64'(o_decrypt[0]), 64'd1);
    for (int i = 0; i < 20; i++) begin
      key_in = {$urandom, $urandom};
      decrypt = i[0];
      i_valid = 1'b1;
      tick();
    end
    chk("stream_full", 64'(k_valid), 64'hFFFF);
    i_valid = 1'b0;
    decrypt = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 5; i++) begin
      key_in = {$urandom, $urandom};
      decrypt = i[0];
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    repeat (2) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(k_valid), 64'h3E00);
    end
    enable = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!k_valid[0] && t < 40);
    chk("stall_latency", 64'(t), 64'd9);
    for (int i = 0; i < 16; i++) begin
      key_in = {$urandom, $urandom};
      decrypt = i[1];
      i_valid = 1'b1;
      tick();
    end
    restart_block = 1'b1;
    key_in = 64'h0123456789ABCDEF;
    tick();
    chk("restart_valid", 64'(k_valid), 64'd0);
    restart_block = 1'b0;
    key_in = KEY;
    decrypt = 1'b0;
    tick();
    chk("restart_next", 64'(k_valid), 64'h8000);
    i_valid = 1'b0;
    repeat (15) tick();
    chk("restart_v16", 64'(k_valid), 64'h0001);
    chk("restart_k16", 64'(sk(16)), 64'(K16));
    for (int i = 0; i < 5; i++) begin
      key_in = {$urandom, $urandom};
      decrypt = i[0];
      i_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(k_valid), 64'd0);
    chk("mid_rst_mode", 64'(o_decrypt), 64'd0);
    chk("mid_rst_kout", 64'(k_out == '0), 64'd1);
    rst = 1'b0;
    key_in = KEY;
    decrypt = 1'b1;
    tick();
    i_valid = 1'b0;
    decrypt = 1'b0;
    t = 1;
    while (!k_valid[0] && t < 40) begin
      tick();
      t++;
    end
    chk("rst_latency", 64'(t), 64'd16);
    chk("rst_k16", 64'(sk(16)), 64'(K1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
